// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer slice.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Fetching this word ends the program.
  localparam logic [31:0] STOP_WORD = 32'hFFFF_FFFF;

  // Opcode field values of the instructions the ID-side decode cares about.
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the instruction in ID needs a register that the
// load currently in EX has not yet produced. Register $0 never creates a hazard.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       stall
);

  // rs is always a source; rt only when the ID instruction reads it.
  always_comb begin
    stall = ex_mem_read && (ex_rt != 5'd0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Central sequencer for the 5-stage pipeline: PC / IF-ID / ID-EX strobes,
// load-use stalls, branch/jump flushes, stop-word drain and halt, statistics.
module pipe_seq_ctrl
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      if_instr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             id_jump,
  input  logic             id_equal,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pc_src_taken,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state, state_next;
  logic [DW-1:0] drain_cnt, drain_cnt_next;
  logic          stall, taken, stop_seen;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .stall       (stall)
  );

  // A stall holds the branch in ID, so it is resolved only once the stall clears;
  // a stop word behind a taken branch is on the wrong path and is ignored.
  always_comb begin
    taken     = !stall && (id_jump || (id_beq && id_equal) || (id_bne && !id_equal));
    stop_seen = (if_instr == STOP_WORD) && !stall && !taken;
  end

  // Next-state and strobe decode; reset forces the safe "frozen" strobes.
  always_comb begin
    // NOTE: every output and next-state term gets a default first, so no path infers a latch.
    state_next     = state;
    drain_cnt_next = drain_cnt;
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b1;
    pc_src_taken   = 1'b0;
    if (!RESET) begin
      case (state)
        RUN: begin
          pc_write     = !stall;
          if_id_write  = !stall;
          id_ex_bubble = stall;
          if_id_flush  = taken;
          pc_src_taken = taken;
          if (stop_seen) begin
            // Freeze the PC and keep the stop word itself out of ID.
            state_next     = DRAIN;
            drain_cnt_next = DW'(DRAIN_CYCLES - 1);
            pc_write       = 1'b0;
            if_id_flush    = 1'b1;
          end
        end
        DRAIN: begin
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = stall;
          if (!stall) begin
            if (drain_cnt == '0) state_next = HALTED;
            else                 drain_cnt_next = drain_cnt - DW'(1);
          end
        end
        HALTED: ;
        default: state_next = RUN;
      endcase
    end
  end

  // State, drain counter and the sticky halted flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      halted    <= (state_next == HALTED);
    end
  end

  // Saturating statistics: active cycles and load-use stall cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (state != HALTED) begin
      if (cycle_count != '1)          cycle_count <= cycle_count + CNT_W'(1);
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: directed vectors, a cycle-level
// behavioural model compared on every falling edge, plus literal checkpoints.
module tb_pipe_seq_ctrl;

  localparam int DRAIN  = 4;
  localparam int CW     = 8;
  localparam int unsigned CMAX = (1 << CW) - 1;
  localparam logic [31:0] PLAIN = 32'h0109_5020;
  localparam logic [31:0] STOPW = 32'hFFFF_FFFF;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [31:0]   if_instr;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_beq, id_bne, id_jump, id_equal, ex_mem_read;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pc_src_taken, halted;
  logic [CW-1:0] cycle_count, stall_count;

  int tests = 0;
  int fails = 0;

  pipe_seq_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .if_instr     (if_instr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_beq       (id_beq),
    .id_bne       (id_bne),
    .id_jump      (id_jump),
    .id_equal     (id_equal),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .pc_src_taken (pc_src_taken),
    .halted       (halted),
    .cycle_count  (cycle_count),
    .stall_count  (stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_RUN, M_DRAIN, M_DONE} mode_t;
  mode_t       m_mode   = M_RUN;
  int          m_left   = 0;   // non-stalled drain cycles still owed
  int unsigned m_cycles = 0;
  int unsigned m_stalls = 0;

  function automatic bit f_stall();
    return ex_mem_read && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit f_taken();
    return !f_stall() && (id_jump || (id_beq && id_equal) || (id_bne && !id_equal));
  endfunction

  function automatic bit f_stop();
    return if_instr == STOPW && !f_stall() && !f_taken();
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_mode = M_RUN; m_left = 0; m_cycles = 0; m_stalls = 0;
    end else begin
      bit s;
      s = f_stall();
      if (m_mode != M_DONE) begin
        if (m_cycles < CMAX) m_cycles++;
        if (s && m_stalls < CMAX) m_stalls++;
      end
      if (m_mode == M_RUN && f_stop()) begin
        m_mode = M_DRAIN;
        m_left = DRAIN;
      end else if (m_mode == M_DRAIN && !s) begin
        m_left--;
        if (m_left == 0) m_mode = M_DONE;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    bit pw, iw, fl, bub, src, s, t;
    s = f_stall();
    t = f_taken();
    if (RESET) begin
      pw = 0; iw = 0; fl = 0; bub = 1; src = 0;
    end else if (m_mode == M_RUN) begin
      pw = !s && !f_stop(); iw = !s; fl = t || f_stop(); bub = s; src = t;
    end else if (m_mode == M_DRAIN) begin
      pw = 0; iw = 1; fl = 1; bub = s; src = 0;
    end else begin
      pw = 0; iw = 0; fl = 0; bub = 1; src = 0;
    end
    check("m_pc_write",     pc_write,     pw);
    check("m_if_id_write",  if_id_write,  iw);
    check("m_if_id_flush",  if_id_flush,  fl);
    check("m_id_ex_bubble", id_ex_bubble, bub);
    check("m_pc_src_taken", pc_src_taken, src);
    check("m_halted",       halted,       (m_mode == M_DONE));
    check("m_cycle_count",  cycle_count,  m_cycles);
    check("m_stall_count",  stall_count,  m_stalls);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    if_instr = PLAIN; id_rs = 5'd8; id_rt = 5'd9; id_uses_rt = 1'b1;
    id_beq = 0; id_bne = 0; id_jump = 0; id_equal = 0;
    ex_mem_read = 0; ex_rt = 5'd0;
  endtask

  task automatic hazard_on();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
  endtask

  // Ticks until halted, starting from the stop cycle already counted as 0.
  task automatic wait_halted(inout int n);
    while (!halted && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    idle();
    repeat (2) tick();
    #2 check("reset_bubble", id_ex_bubble, 1);
    check("reset_pc_write", pc_write, 0);
    RESET = 1'b0;
    #1 check("run_pc_write", pc_write, 1);
    check("run_cycle0", cycle_count, 0);
    repeat (3) tick();
    #2 check("run_cycle3", cycle_count, 3);
    check("run_stalls0", stall_count, 0);

    // load-use hazard on rs
    hazard_on();
    #1 check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_bubble", id_ex_bubble, 1);
    tick(); idle();
    #2 check("lu_stall_count", stall_count, 1);
    check("lu_release", pc_write, 1);
    // load into $0: no hazard
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 check("lu_r0_no_stall", pc_write, 1);
    tick(); idle();
    // rt hazard only when rt is a source
    ex_mem_read = 1; ex_rt = 5'd9; id_uses_rt = 1'b0;
    #1 check("lu_rt_unused", if_id_write, 1);
    id_uses_rt = 1'b1;
    #1 check("lu_rt_used", if_id_write, 0);
    tick(); idle();
    #2 check("lu_stall_count2", stall_count, 2);

    // branches and jumps
    id_beq = 1; id_equal = 1;
    #1 check("beq_taken", pc_src_taken, 1);
    check("beq_flush", if_id_flush, 1);
    tick(); idle();
    id_beq = 1; id_equal = 0;
    #1 check("beq_not_taken", if_id_flush, 0);
    tick(); idle();
    id_bne = 1; id_equal = 0;
    #1 check("bne_taken", pc_src_taken, 1);
    tick(); idle();
    id_jump = 1;
    #1 check("jump_taken", pc_src_taken, 1);
    tick(); idle();
    id_beq = 1; id_equal = 1; hazard_on();
    #1 check("stall_beats_branch", pc_src_taken, 0);
    tick(); ex_mem_read = 0;
    #1 check("branch_after_stall", pc_src_taken, 1);
    tick(); idle();

    // stop word on the wrong path is ignored
    if_instr = STOPW; id_jump = 1;
    tick(); idle();
    #1 check("wrong_path_stop", pc_write, 1);
    tick();

    // stop word during a stall, then a stall inside DRAIN
    if_instr = STOPW; hazard_on();
    #1 check("stop_stalled_pc", pc_write, 0);
    check("stop_stalled_flush", if_id_flush, 0);
    tick(); ex_mem_read = 0;
    #1 check("stop_after_stall_pc", pc_write, 0);
    check("stop_after_stall_flush", if_id_flush, 1);
    n = 0;
    tick(); n++; idle(); hazard_on();       // DRAIN, stalled
    tick(); n++; idle();
    wait_halted(n);
    check("halt_delay_stalled", n, 6);
    repeat (3) tick();

    // reset out of HALTED, then plain stop: halted exactly 5 cycles later
    RESET = 1'b1;
    #1 check("reset_halted_clear", halted, 0);
    tick(); RESET = 1'b0;
    tick();
    if_instr = STOPW;
    #1 check("stop_pc_write", pc_write, 0);
    n = 0;
    tick(); n++; idle();
    wait_halted(n);
    check("halt_delay", n, 5);
    repeat (3) tick();

    // asynchronous reset between edges in the middle of DRAIN
    RESET = 1'b1;
    tick(); RESET = 1'b0;
    tick();
    if_instr = STOPW;
    tick(); idle();
    tick();
    #2 RESET = 1'b1;
    #1 check("async_pc_write", pc_write, 0);
    check("async_bubble", id_ex_bubble, 1);
    check("async_halted", halted, 0);
    check("async_cycles", cycle_count, 0);
    tick(); RESET = 1'b0;
    #1 check("resume_run", pc_write, 1);

    // saturation of both counters
    hazard_on();
    repeat (260) tick();
    #1 check("sat_stalls", stall_count, CMAX);
    check("sat_cycles", cycle_count, CMAX);
    idle();
    repeat (2) tick();
    #1 check("sat_hold", cycle_count, CMAX);

    @(negedge CLK);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
